// File: rtl/rpn_stack_engine.sv
// Reverse-Polish arithmetic engine. Takes operand/operator/result tokens, drives an
// external LIFO through push/pop strobes and returns results over a valid/ready port.
module rpn_stack_engine #(
  parameter int unsigned data_count = 3,
  parameter int unsigned data_width = 16
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            tok_valid,
  output logic                            tok_ready,
  input  logic [1:0]                      tok_type,
  input  logic [data_width-1:0]           tok_data,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [data_width-1:0]           res_data,
  output logic                            stk_push,
  output logic                            stk_pop,
  output logic [data_width-1:0]           stk_data_in,
  input  logic [data_width-1:0]           stk_data_out,
  input  logic                            stk_empty,
  input  logic                            stk_full,
  output logic [$clog2(data_count+1)-1:0] depth,
  output logic                            err_overflow,
  output logic                            err_underflow
);

  localparam int unsigned depth_w = $clog2(data_count + 1);
  localparam logic [depth_w-1:0] depth_max = depth_w'(data_count);
  localparam logic [depth_w-1:0] depth_one = depth_w'(1);
  localparam logic [depth_w-1:0] depth_two = depth_w'(2);

  typedef enum logic [3:0] {
    StIdle, StPushOp, StPopB, StPopA, StCalc, StPushR, StPopR, StCap, StOut, StErr
  } state_e;

  state_e                state_q, state_d;
  logic [depth_w-1:0]    depth_q, depth_d;
  logic [1:0]            op_q, op_d;
  logic [data_width-1:0] b_q, b_d;
  logic [data_width-1:0] data_in_q, data_in_d;
  logic [data_width-1:0] res_data_q, res_data_d;
  logic                  tok_ready_q, tok_ready_d;
  logic                  res_valid_q, res_valid_d;
  logic                  push_q, push_d;
  logic                  pop_q, pop_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [data_width-1:0] alu_result;

  // Operand a is the deeper entry; it is on stk_data_out during CALC.
  always_comb begin
    unique case (op_q)
      2'b00:   alu_result = stk_data_out + b_q;
      2'b01:   alu_result = stk_data_out - b_q;
      2'b10:   alu_result = stk_data_out * b_q;
      default: alu_result = stk_data_out & b_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    op_d       = op_q;
    b_d        = b_q;
    data_in_d  = data_in_q;
    res_data_d = res_data_q;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tok_valid && tok_ready_q) begin
          unique case (tok_type)
            2'b00: begin
              if (depth_q < depth_max && !stk_full) begin
                state_d   = StPushOp;
                data_in_d = tok_data;
              end else begin
                state_d = StErr;
                ovf_d   = 1'b1;
              end
            end
            2'b01: begin
              if (depth_q < depth_two) begin
                state_d = StErr;
                unf_d   = 1'b1;
              end else begin
                state_d = StPopB;
                op_d    = tok_data[1:0];
              end
            end
            2'b10: begin
              if (depth_q == '0 || stk_empty) begin
                state_d = StErr;
                unf_d   = 1'b1;
              end else begin
                state_d = StPopR;
              end
            end
            2'b11: ;  // reserved token is swallowed without side effects
          endcase
        end
      end
      StPushOp: begin
        state_d = StIdle;
        if (depth_q < depth_max) depth_d = depth_q + depth_one;
      end
      StPopB: state_d = StPopA;
      StPopA: begin
        state_d = StCalc;
        b_d     = stk_data_out;
      end
      StCalc: begin
        state_d   = StPushR;
        data_in_d = alu_result;
      end
      StPushR: begin
        state_d = StIdle;
        if (depth_q != '0) depth_d = depth_q - depth_one;
      end
      StPopR: begin
        state_d = StCap;
        if (depth_q != '0) depth_d = depth_q - depth_one;
      end
      StCap: begin
        state_d    = StOut;
        res_data_d = stk_data_out;
      end
      StOut: if (res_ready) state_d = StIdle;
      StErr: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    push_d      = (state_d == StPushOp) || (state_d == StPushR);
    pop_d       = (state_d == StPopB) || (state_d == StPopA) || (state_d == StPopR);
    res_valid_d = (state_d == StOut);
    // One dead cycle after a result handshake before new tokens are taken.
    tok_ready_d = (state_d == StIdle) && (state_q != StOut);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      depth_q     <= '0;
      op_q        <= '0;
      b_q         <= '0;
      data_in_q   <= '0;
      res_data_q  <= '0;
      tok_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      op_q        <= op_d;
      b_q         <= b_d;
      data_in_q   <= data_in_d;
      res_data_q  <= res_data_d;
      tok_ready_q <= tok_ready_d;
      res_valid_q <= res_valid_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign tok_ready     = tok_ready_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign stk_push      = push_q;
  assign stk_pop       = pop_q;
  assign stk_data_in   = data_in_q;
  assign depth         = depth_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_rpn_stack_engine.sv
// Bench for rpn_stack_engine: behavioural LIFO attached to the stack port, token-level
// reference stack model, directed scenarios followed by random token streams.
module tb_rpn_stack_engine;

  localparam int DC = 3;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          tok_valid = 1'b0;
  logic          tok_ready;
  logic [1:0]    tok_type = 2'b00;
  logic [DW-1:0] tok_data = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          stk_push;
  logic          stk_pop;
  logic [DW-1:0] stk_data_in;
  logic [DW-1:0] stk_data_out;
  logic          stk_empty;
  logic          stk_full;
  logic [1:0]    depth;
  logic          err_overflow;
  logic          err_underflow;

  always #5 clock = ~clock;

  rpn_stack_engine #(.data_count(DC), .data_width(DW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_type     (tok_type),
    .tok_data     (tok_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_empty    (stk_empty),
    .stk_full     (stk_full),
    .depth        (depth),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
  );

  // Attached LIFO: top appears on stk_data_out the cycle after a pop is sampled.
  logic [DW-1:0] mem [8];
  logic [2:0]    sp = '0;
  always @(posedge clock) begin
    if (!reset_n) begin
      sp           <= '0;
      stk_data_out <= '0;
    end else if (stk_push && sp < 3'(DC)) begin
      mem[sp] <= stk_data_in;
      sp      <= sp + 3'd1;
    end else if (stk_pop && sp != '0) begin
      stk_data_out <= mem[sp - 3'd1];
      sp           <= sp - 3'd1;
    end
  end
  assign stk_empty = (sp == '0);
  assign stk_full  = (sp == 3'(DC));

  int n_checks = 0;
  int n_pass = 0;
  logic [DW-1:0] push_log[$];
  logic [DW-1:0] ref_q[$];
  logic [DW-1:0] last_res = '0;
  int pop_cnt, ovf_cnt, unf_cnt, clash_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one cycle and record what the engine did on the stack port.
  task automatic tick();
    @(negedge clock);
    #1;
    if (reset_n) begin
      if (stk_push) push_log.push_back(stk_data_in);
      if (stk_pop) pop_cnt++;
      if (stk_push && stk_pop) clash_cnt++;
      if (err_overflow) ovf_cnt++;
      if (err_underflow) unf_cnt++;
    end
  endtask

  function automatic logic [DW-1:0] apply_op(input logic [1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic [31:0] p;
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b10: begin
        p = 32'(a) * 32'(b);
        return p[DW-1:0];
      end
      default: return a & b;
    endcase
  endfunction

  task automatic do_reset();
    reset_n   = 1'b0;
    tok_valid = 1'b0;
    res_ready = 1'b0;
    tick();
    check_eq("rst_tok_ready", 32'(tok_ready), 0);
    check_eq("rst_res_valid", 32'(res_valid), 0);
    check_eq("rst_push_pop", {stk_push, stk_pop}, 0);
    check_eq("rst_errs", {err_overflow, err_underflow}, 0);
    check_eq("rst_depth", 32'(depth), 0);
    check_eq("rst_res_data", 32'(res_data), 0);
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("rst_release_ready", 32'(tok_ready), 1);
    ref_q.delete();
  endtask

  task automatic run_tok(input logic [1:0] t, input logic [DW-1:0] d, input int stall);
    logic [DW-1:0] a, b, r, res_val;
    logic [DW-1:0] exp_push[$];
    int exp_pop, exp_ovf, exp_unf, n;
    logic exp_res;
    exp_pop = 0; exp_ovf = 0; exp_unf = 0; exp_res = 1'b0; res_val = '0;
    case (t)
      2'b00: begin
        if (ref_q.size() < DC) begin
          exp_push.push_back(d);
          ref_q.push_back(d);
        end else exp_ovf = 1;
      end
      2'b01: begin
        if (ref_q.size() < 2) exp_unf = 1;
        else begin
          b = ref_q.pop_back();
          a = ref_q.pop_back();
          r = apply_op(d[1:0], a, b);
          exp_pop = 2;
          exp_push.push_back(r);
          ref_q.push_back(r);
        end
      end
      2'b10: begin
        if (ref_q.size() == 0) exp_unf = 1;
        else begin
          res_val = ref_q.pop_back();
          exp_pop = 1;
          exp_res = 1'b1;
        end
      end
      default: ;
    endcase

    n = 0;
    while (!tok_ready && n < 50) begin tick(); n++; end
    if (n >= 50) check_eq("tok_ready_timeout", 0, 1);
    push_log.delete();
    pop_cnt = 0; ovf_cnt = 0; unf_cnt = 0; clash_cnt = 0;
    tok_valid = 1'b1; tok_type = t; tok_data = d;
    tick();
    tok_valid = 1'b0; tok_data = 16'($urandom);

    if (exp_res) begin
      n = 0;
      while (!res_valid && n < 20) begin tick(); n++; end
      if (n >= 20) check_eq("res_valid_timeout", 0, 1);
      for (int i = 0; i < stall; i++) begin
        check_eq("stall_valid", 32'(res_valid), 1);
        check_eq("stall_data", 32'(res_data), 32'(res_val));
        check_eq("stall_tok_ready", 32'(tok_ready), 0);
        tick();
      end
      check_eq("res_data", 32'(res_data), 32'(res_val));
      last_res  = res_data;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check_eq("res_valid_drop", 32'(res_valid), 0);
      check_eq("res_gap_ready", 32'(tok_ready), 0);
      tick();
      check_eq("res_ready_back", 32'(tok_ready), 1);
    end else begin
      n = 0;
      while (!tok_ready && n < 20) begin tick(); n++; end
      if (n >= 20) check_eq("done_timeout", 0, 1);
    end

    check_eq("push_count", push_log.size(), exp_push.size());
    for (int i = 0; i < exp_push.size() && i < push_log.size(); i++)
      check_eq("push_value", 32'(push_log[i]), 32'(exp_push[i]));
    check_eq("pop_count", pop_cnt, exp_pop);
    check_eq("ovf_cycles", ovf_cnt, exp_ovf);
    check_eq("unf_cycles", unf_cnt, exp_unf);
    check_eq("strobe_clash", clash_cnt, 0);
    check_eq("depth", 32'(depth), ref_q.size());
  endtask

  initial begin
    do_reset();

    // add
    run_tok(2'b00, 16'h0003, 0);
    run_tok(2'b00, 16'h0004, 0);
    run_tok(2'b01, 16'h0000, 0);
    check_eq("plan_add_push", push_log.size() == 1 ? 32'(push_log[0]) : 32'hDEAD, 32'h0007);
    run_tok(2'b10, 16'h0000, 0);
    check_eq("plan_add_res", 32'(last_res), 32'h0007);
    check_eq("plan_add_depth", 32'(depth), 0);

    // sub and mul corners
    run_tok(2'b00, 16'h0005, 0);
    run_tok(2'b00, 16'h0007, 0);
    run_tok(2'b01, 16'h0001, 0);
    run_tok(2'b10, 16'h0000, 1);
    check_eq("plan_sub_res", 32'(last_res), 32'hFFFE);
    run_tok(2'b00, 16'h00FF, 0);
    run_tok(2'b00, 16'h0101, 0);
    run_tok(2'b01, 16'h0002, 0);
    run_tok(2'b10, 16'h0000, 0);
    check_eq("plan_mul_ffff", 32'(last_res), 32'hFFFF);
    run_tok(2'b00, 16'h0100, 0);
    run_tok(2'b00, 16'h0100, 0);
    run_tok(2'b01, 16'h0002, 0);
    run_tok(2'b10, 16'h0000, 0);
    check_eq("plan_mul_zero", 32'(last_res), 32'h0000);

    // overflow
    run_tok(2'b00, 16'hFFFF, 0);
    run_tok(2'b00, 16'hAAAA, 0);
    run_tok(2'b00, 16'h5555, 0);
    run_tok(2'b00, 16'h0F0F, 0);
    check_eq("plan_ovf_pulse", ovf_cnt, 1);
    check_eq("plan_ovf_nopush", push_log.size(), 0);
    check_eq("plan_ovf_depth", 32'(depth), 3);
    run_tok(2'b11, 16'h1234, 0);
    run_tok(2'b10, 16'h0000, 5);
    check_eq("plan_stall_res", 32'(last_res), 32'h5555);

    // underflow after reset
    do_reset();
    run_tok(2'b00, 16'h0001, 0);
    run_tok(2'b01, 16'h0000, 0);
    check_eq("plan_unf_nopop", pop_cnt, 0);
    check_eq("plan_unf_depth", 32'(depth), 1);
    run_tok(2'b10, 16'h0000, 0);
    check_eq("plan_unf_res", 32'(last_res), 32'h0001);
    run_tok(2'b10, 16'h0000, 0);
    check_eq("plan_unf_second", unf_cnt, 1);

    // reset in the middle of an operator
    run_tok(2'b00, 16'h0009, 0);
    run_tok(2'b00, 16'h000A, 0);
    tok_valid = 1'b1; tok_type = 2'b01; tok_data = 16'h0000;
    tick();
    tok_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    check_eq("midrst_push_pop", {stk_push, stk_pop}, 0);
    check_eq("midrst_depth", 32'(depth), 0);
    check_eq("midrst_res_valid", 32'(res_valid), 0);
    reset_n = 1'b1;
    tick();
    check_eq("midrst_ready", 32'(tok_ready), 1);
    ref_q.delete();

    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      logic [1:0] t;
      r = $urandom_range(0, 99);
      t = (r < 40) ? 2'b00 : (r < 70) ? 2'b01 : (r < 95) ? 2'b10 : 2'b11;
      run_tok(t, 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rpn_stack_engine.md
Name: rpn_stack_engine

Overview:
- Reverse-Polish arithmetic engine that drives an external LIFO through its push/pop/empty/full port set; this block is the initiator of that interface.
- Accepts a token stream of operands, operators and result requests over a valid/ready handshake.
- Issues stack pushes and pops, computes results, and returns them over a second valid/ready handshake.
- Sits between a command source and the stack instance.

Parameters:
data_count, 3, depth of the attached stack (maximum entries)
data_width, 16, operand/result width in bits; must match the stack's data_width

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous, active-low reset
tok_valid  input  1  token present
tok_ready  output  1  engine can accept a token this cycle
tok_type  input  2  00 operand, 01 operator, 10 result request, 11 reserved
tok_data  input  data_width  operand value; for operators bits[1:0]: 00 add, 01 sub, 10 mul, 11 and
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  data_width  result value
stk_push  output  1  push strobe to stack
stk_pop  output  1  pop strobe to stack
stk_data_in  output  data_width  value to push
stk_data_out  input  data_width  stack top, valid one cycle after a pop is sampled
stk_empty  input  1  stack empty
stk_full  input  1  stack full
depth  output  $clog2(data_count+1)  engine's count of stack entries
err_overflow  output  1  one-cycle pulse on rejected push
err_underflow  output  1  one-cycle pulse on rejected pop

Behaviour:
- One clock (clock) and a synchronous active-low reset (reset_n).
- All outputs are registered.
- Reset values: tok_ready=0 during reset and 1 in the first cycle after; all other outputs 0; FSM in IDLE.
- Reset mid-operation abandons the pending token or result. The stack must be reset in the same cycle (integration rule).
- Token acceptance: a token is accepted on a clock edge where tok_valid=1 and tok_ready=1. tok_ready=1 only in IDLE.
- Stack strobes: stk_push and stk_pop are never asserted together. Each strobe is asserted for exactly one cycle per entry.
- Operand, accepted in cycle N:
  - If depth<data_count and stk_full=0: cycle N+1 has stk_push=1, stk_data_in=tok_data; depth+1 at the end of N+1; return to IDLE.
  - Else: no push; err_overflow=1 in N+1 only; token is dropped.
- Operator, accepted in cycle N:
  - If depth<2: err_underflow pulse in N+1; no stack access.
  - Else the sequence is:
    - N+1 POP_B: stk_pop=1.
    - N+2 POP_A: stk_pop=1; capture b=stk_data_out.
    - N+3 CALC: capture a=stk_data_out.
    - N+4 PUSH_R: stk_push=1, stk_data_in=f(a,b); depth ends at depth-1.
    - Return to IDLE.
  - tok_ready=1 again from N+5.
- Arithmetic, modulo 2^data_width:
  - add: a+b.
  - sub: a-b (a is deeper, b was top).
  - mul: low data_width bits of a*b.
  - and: bitwise a&b.
- Result request, accepted in cycle N:
  - If depth==0 or stk_empty=1: err_underflow pulse in N+1.
  - Else:
    - N+1 POP_R: stk_pop=1.
    - N+2 CAP: latch res_data.
    - N+3 OUT: res_valid=1.
  - res_valid and res_data stay stable until the edge where res_ready=1; then res_valid=0 in the next cycle and return to IDLE.
  - The result is consumed (depth-1).
- Reserved type 11: token accepted and dropped; err_underflow=0 and err_overflow=0; no stack access.
- depth saturates at 0 and data_count and is never changed by a rejected token.
- States: IDLE, PUSH_OP, POP_B, POP_A, CALC, PUSH_R, POP_R, CAP, OUT, ERR (single-cycle pulse state, then IDLE).

Test Plan:
- data_count=3, data_width=16 throughout.
- Operands 0x0003, 0x0004, operator add, result request -> three stk_push strobes (3, 4, then 7); res_data=0x0007; depth 0 afterward.
- Operands 0x0005, 0x0007, operator sub, result -> stk_data_in=0xFFFE; res_data=0xFFFE. Repeat with mul 0x00FF*0x0101 -> 0xFFFF, and mul 0x0100*0x0100 -> 0x0000.
- Operands 0xFFFF, 0xAAAA, 0x5555, 0x0F0F back-to-back -> first three pushed, depth=3; fourth gives err_overflow for one cycle and no stk_push; depth stays 3.
- After reset, push 0x0001, then operator add -> err_underflow pulse, no stk_pop, depth=1. Then two result requests -> first returns 0x0001; second gives err_underflow.
- Result ready with res_ready=0 for 5 cycles -> res_valid=1, res_data stable, tok_ready=0 throughout; res_ready=1 -> res_valid=0 next cycle, tok_ready=1 the cycle after.
- reset_n=0 in cycle N+2 of an operator -> from N+3 stk_push=0, stk_pop=0, depth=0, res_valid=0; tok_ready=1 once reset_n returns high.
